nn_inference_sequencer: RTL and testbench

Synthesizable run controller for the `net` digit-recognition core. It replaces bench-driven stimulus with on-chip sequencing: for each sample it streams the 784 pixel words from a synchronous sample memory into `net`, fetches the stored label, and waits for the classification result. It then compares result and label and accumulates match/sample counts, so accuracy over a regression can be read from registers.

---
 rtl/nn_inference_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_nn_inference_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_sequencer
// Purpose  : On-chip run controller for the `net` digit classifier. For each
//            sample it streams the pixel words from a synchronous sample
//            memory into `net`, reads the stored label, waits for the class
//            result (bounded by a timeout) and accumulates match/sample
//            counts so regression accuracy can be read back from registers.
// Ports    : clk, rst (sync, active high)
//            start / num_samples      - run request and sample count
//            mem_rd_en/addr/data      - sample memory (data 1 cycle after en)
//            net_valid / net_data     - pixel stream to `net`
//            net_out_valid/net_out_data - class result from `net`
//            busy, done, result_valid, result_match,
//            match_count, sample_count, timeout_err - status
// Revision : 1.0 - initial release
// ============================================================================
module nn_inference_sequencer #(
    parameter int dataWidth     = 16,
    parameter int nnDataInSize  = 784,
    parameter int outData       = 10,
    parameter int outWidth      = $clog2(outData),
    parameter int numSamples    = 1000,
    parameter int cntWidth      = $clog2(numSamples + 1),
    parameter int addrWidth     = $clog2(numSamples * (nnDataInSize + 1)),
    parameter int timeoutCycles = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [cntWidth-1:0]  num_samples,
    output logic                 mem_rd_en,
    output logic [addrWidth-1:0] mem_rd_addr,
    input  logic [dataWidth-1:0] mem_rd_data,
    output logic                 net_valid,
    output logic [dataWidth-1:0] net_data,
    input  logic                 net_out_valid,
    input  logic [outWidth-1:0]  net_out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid,
    output logic                 result_match,
    output logic [cntWidth-1:0]  match_count,
    output logic [cntWidth-1:0]  sample_count,
    output logic                 timeout_err
);

    localparam int PIX_W  = $clog2(nnDataInSize);
    localparam int WAIT_W = $clog2(timeoutCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LABEL = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [cntWidth-1:0]   r_target;
    logic [cntWidth-1:0]   r_match_count;
    logic [cntWidth-1:0]   r_sample_count;
    logic [addrWidth-1:0]  r_addr;
    logic [PIX_W-1:0]      r_pix;
    logic [WAIT_W-1:0]     r_wait;
    logic [dataWidth-1:0]  r_expected;
    logic                  r_net_valid;
    logic                  r_label_phase;
    logic                  r_result_valid;
    logic                  r_result_match;
    logic                  r_timeout_err;

    logic [cntWidth-1:0]   w_clamped;
    logic [dataWidth-1:0]  w_out_ext;
    logic                  w_last_pixel;
    logic                  w_hit;
    logic                  w_expire;
    logic                  w_complete;
    logic                  w_match;
    logic                  w_last_sample;
    logic                  w_rd_en;
    logic                  w_busy;
    logic                  w_done;

    assign w_clamped     = (num_samples > cntWidth'(numSamples)) ? cntWidth'(numSamples)
                                                                 : num_samples;
    assign w_out_ext     = {{(dataWidth - outWidth){1'b0}}, net_out_data};
    assign w_last_pixel  = (r_pix == PIX_W'(nnDataInSize - 1));
    // A result arriving in the final wait cycle wins over the timeout.
    assign w_hit         = (r_state == S_WAIT) && net_out_valid;
    assign w_expire      = (r_state == S_WAIT) && !net_out_valid
                           && (r_wait == WAIT_W'(timeoutCycles - 1));
    assign w_complete    = w_hit || w_expire;
    assign w_match       = w_hit && (r_expected == w_out_ext);
    assign w_last_sample = ((r_sample_count + cntWidth'(1)) == r_target);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (w_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (w_last_pixel) begin
                    w_next_state = S_LABEL;
                end
            end
            S_LABEL: begin
                w_rd_en      = 1'b1;
                w_busy       = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (w_complete) begin
                    w_next_state = w_last_sample ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address walk, pixel/label alignment, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target       <= '0;
            r_match_count  <= '0;
            r_sample_count <= '0;
            r_addr         <= '0;
            r_pix          <= '0;
            r_wait         <= '0;
            r_expected     <= '0;
            r_net_valid    <= 1'b0;
            r_label_phase  <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_match <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            // Memory answers one cycle after the read, so the pixel strobe
            // and the label capture are the read phases delayed by one.
            r_net_valid    <= (r_state == S_FETCH);
            r_label_phase  <= (r_state == S_LABEL);
            r_result_valid <= w_complete;
            r_result_match <= w_match;
            if (r_label_phase) begin
                r_expected <= mem_rd_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target       <= w_clamped;
                        r_match_count  <= '0;
                        r_sample_count <= '0;
                        r_timeout_err  <= 1'b0;
                        r_addr         <= '0;
                        r_pix          <= '0;
                    end
                end
                // Pixels and label are packed back to back and samples are
                // contiguous, so the read address simply keeps counting.
                S_FETCH: begin
                    r_addr <= r_addr + addrWidth'(1);
                    r_pix  <= w_last_pixel ? '0 : r_pix + PIX_W'(1);
                end
                S_LABEL: begin
                    r_addr <= r_addr + addrWidth'(1);
                    r_wait <= '0;
                end
                S_WAIT: begin
                    r_wait <= r_wait + WAIT_W'(1);
                    if (w_complete) begin
                        r_sample_count <= r_sample_count + cntWidth'(1);
                    end
                    if (w_match) begin
                        r_match_count <= r_match_count + cntWidth'(1);
                    end
                    if (w_expire) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en    = w_rd_en;
    assign mem_rd_addr  = w_rd_en ? r_addr : '0;
    // The sample memory's output register is the pipeline stage for pixels.
    assign net_valid    = r_net_valid;
    assign net_data     = r_net_valid ? mem_rd_data : '0;
    assign busy         = w_busy;
    assign done         = w_done;
    assign result_valid = r_result_valid;
    assign result_match = r_result_match;
    assign match_count  = r_match_count;
    assign sample_count = r_sample_count;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_nn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_inference_sequencer
// Purpose  : Self-checking bench for nn_inference_sequencer. A memory model
//            serves pixels/labels, a per-run timeline of expected outputs is
//            built from the sample/response description, and `net` responses
//            (plus spurious strobes outside the wait window) are replayed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_inference_sequencer;

    localparam int DW   = 16;
    localparam int NPIX = 784;
    localparam int OUTW = 4;
    localparam int NS   = 1000;
    localparam int CW   = 10;
    localparam int AW   = 20;
    localparam int TMO  = 4096;
    localparam int SPAN = NPIX + 1;
    localparam int MAXC = 12000;
    localparam int NSIG = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CW-1:0]   num_samples;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic [DW-1:0]   mem_rd_data;
    logic            net_valid;
    logic [DW-1:0]   net_data;
    logic            net_out_valid;
    logic [OUTW-1:0] net_out_data;
    logic            busy;
    logic            done;
    logic            result_valid;
    logic            result_match;
    logic [CW-1:0]   match_count;
    logic [CW-1:0]   sample_count;
    logic            timeout_err;

    always #5 clk = ~clk;

    nn_inference_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_samples   (num_samples),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .net_valid     (net_valid),
        .net_data      (net_data),
        .net_out_valid (net_out_valid),
        .net_out_data  (net_out_data),
        .busy          (busy),
        .done          (done),
        .result_valid  (result_valid),
        .result_match  (result_match),
        .match_count   (match_count),
        .sample_count  (sample_count),
        .timeout_err   (timeout_err)
    );

    // ---------------- sample memory model ----------------
    int lbl [0:NS-1];
    int cls [0:NS-1];
    int lat [0:NS-1];   // cycles after first WAIT cycle; -1 = never answers

    function automatic logic [DW-1:0] pix(input int a);
        return DW'((a * 40503 + 1234) ^ (a >>> 3));
    endfunction

    function automatic logic [DW-1:0] mem_word(input int a);
        if ((a % SPAN) == SPAN - 1) return DW'(lbl[a / SPAN]);
        return pix(a);
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(int'(mem_rd_addr));
        else           mem_rd_data <= DW'($urandom);
    end

    // ---------------- expected timeline ----------------
    int e_en [0:MAXC-1], e_addr [0:MAXC-1], e_nv [0:MAXC-1], e_nd [0:MAXC-1];
    int e_busy [0:MAXC-1], e_done [0:MAXC-1], e_rv [0:MAXC-1], e_rm [0:MAXC-1];
    int e_sc [0:MAXC-1], e_mc [0:MAXC-1], e_tmo [0:MAXC-1], e_tevt [0:MAXC-1];
    int d_nov [0:MAXC-1], d_nod [0:MAXC-1];
    int m_sc, m_mc, m_tmo;

    int nbad [0:NSIG-1], fcyc [0:NSIG-1];
    logic [31:0] fobs [0:NSIG-1], fexp [0:NSIG-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic note(input int i, input int c, input logic [31:0] obs, input logic [31:0] exp);
        if (obs !== exp) begin
            if (nbad[i] == 0) begin
                fcyc[i] = c; fobs[i] = obs; fexp[i] = exp;
            end
            nbad[i]++;
        end
    endtask

    task automatic chk_seq(input string tag, input int i);
        total++;
        assert (nbad[i] === 0) else begin
            bad++;
            $error("FAIL %s: %0d bad cycles, first at cycle %0d got %0h want %0h",
                   tag, nbad[i], fcyc[i], fobs[i], fexp[i]);
        end
    endtask

    // Builds the cycle-by-cycle expectation for a run of n samples, with the
    // start accepted at edge 0 (cycle 1 is the first cycle after it).
    task automatic build(input int n, output int last);
        int t, ws, r, sc, mc, tm;
        for (int c = 0; c < MAXC; c++) begin
            e_en[c] = 0; e_addr[c] = 0; e_nv[c] = 0; e_nd[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_rv[c] = 0; e_rm[c] = 0;
            e_tevt[c] = 0;
            d_nov[c] = ($urandom_range(0, 15) == 0) ? 1 : 0;
            d_nod[c] = $urandom_range(0, 15);
        end
        t = 1;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < SPAN; k++) begin
                e_en[t + k]   = 1;
                e_addr[t + k] = s * SPAN + k;
            end
            for (int k = 0; k < NPIX; k++) begin
                e_nv[t + 1 + k] = 1;
                e_nd[t + 1 + k] = int'(pix(s * SPAN + k));
            end
            ws = t + SPAN;
            if (lat[s] >= 0) r = ws + lat[s] + 1;
            else             r = ws + TMO;
            for (int c = ws; c < r; c++) d_nov[c] = 0;
            if (lat[s] >= 0) begin
                d_nov[ws + lat[s]] = 1;
                d_nod[ws + lat[s]] = cls[s];
                e_rm[r] = (lbl[s] == cls[s]) ? 1 : 0;
            end else begin
                e_tevt[r] = 1;
            end
            e_rv[r] = 1;
            t = r;
        end
        e_done[t] = 1;
        for (int c = 1; c < t; c++) e_busy[c] = 1;
        last = t + 1;
        sc = 0; mc = 0; tm = 0;
        for (int c = 1; c <= last; c++) begin
            if (e_rv[c] != 0) begin
                sc++;
                mc += e_rm[c];
            end
            if (e_tevt[c] != 0) tm = 1;
            e_sc[c] = sc; e_mc[c] = mc; e_tmo[c] = tm;
        end
        m_sc = sc; m_mc = mc; m_tmo = tm;
    endtask

    task automatic check_zero(input string name);
        chk({name, " busy"},         32'(busy),         0);
        chk({name, " done"},         32'(done),         0);
        chk({name, " mem_rd_en"},    32'(mem_rd_en),    0);
        chk({name, " net_valid"},    32'(net_valid),    0);
        chk({name, " result_valid"}, 32'(result_valid), 0);
        chk({name, " sample_count"}, 32'(sample_count), 0);
        chk({name, " match_count"},  32'(match_count),  0);
        chk({name, " timeout_err"},  32'(timeout_err),  0);
    endtask

    // Called at #1 after a clock edge with the DUT idle.
    task automatic run(input string name, input int n, input int restart_c, input int abort_c);
        int last;
        bit aborted;
        aborted = 0;
        build(n, last);
        for (int i = 0; i < NSIG; i++) nbad[i] = 0;
        start       = 1'b1;
        num_samples = CW'(n);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start         = (c == restart_c);
            if (c == restart_c) num_samples = CW'(5);
            net_out_valid = d_nov[c][0];
            net_out_data  = OUTW'(d_nod[c]);
            note(0, c, 32'(mem_rd_en), e_en[c]);
            if (e_en[c] != 0) note(1, c, 32'(mem_rd_addr), e_addr[c]);
            note(2, c, 32'(net_valid), e_nv[c]);
            if (e_nv[c] != 0) note(3, c, 32'(net_data), e_nd[c]);
            note(4, c, 32'(busy), e_busy[c]);
            note(5, c, 32'(done), e_done[c]);
            note(6, c, 32'(result_valid), e_rv[c]);
            if (e_rv[c] != 0) note(7, c, 32'(result_match), e_rm[c]);
            note(8, c, 32'(sample_count), e_sc[c]);
            note(9, c, 32'(match_count), e_mc[c]);
            note(10, c, 32'(timeout_err), e_tmo[c]);
            if (c == abort_c) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst           = 1'b0;
                start         = 1'b0;
                net_out_valid = 1'b0;
                check_zero({name, " after reset"});
                aborted = 1;
                break;
            end
        end
        net_out_valid = 1'b0;
        chk_seq({name, " mem_rd_en"},    0);
        chk_seq({name, " mem_rd_addr"},  1);
        chk_seq({name, " net_valid"},    2);
        chk_seq({name, " net_data"},     3);
        chk_seq({name, " busy"},         4);
        chk_seq({name, " done"},         5);
        chk_seq({name, " result_valid"}, 6);
        chk_seq({name, " result_match"}, 7);
        chk_seq({name, " sample_count"}, 8);
        chk_seq({name, " match_count"},  9);
        chk_seq({name, " timeout_err"},  10);
        if (!aborted) begin
            chk({name, " final sample_count"}, 32'(sample_count), m_sc);
            chk({name, " final match_count"},  32'(match_count),  m_mc);
            chk({name, " final timeout_err"},  32'(timeout_err),  m_tmo);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0;
        net_out_valid = 1'b0; net_out_data = '0;
        for (int s = 0; s < NS; s++) begin
            lbl[s] = 0; cls[s] = 0; lat[s] = 2;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // one sample, label 7, net answers 7
        lbl[0] = 7; cls[0] = 7; lat[0] = 5;
        run("single", 1, 0, 0);
        chk("single match_count", 32'(match_count), 1);
        chk("single sample_count", 32'(sample_count), 1);

        // three samples, labels 3,5,9 vs answers 3,4,9
        lbl[0] = 3; lbl[1] = 5; lbl[2] = 9;
        cls[0] = 3; cls[1] = 4; cls[2] = 9;
        for (int s = 0; s < 3; s++) lat[s] = $urandom_range(2, 20);
        run("three", 3, 0, 0);
        chk("three match_count", 32'(match_count), 2);
        chk("three sample_count", 32'(sample_count), 3);

        // zero samples
        run("zero", 0, 0, 0);
        chk("zero sample_count", 32'(sample_count), 0);

        // net never answers
        for (int s = 0; s < 2; s++) begin
            lbl[s] = $urandom_range(0, 9); lat[s] = -1;
        end
        run("timeout", 2, 0, 0);
        chk("timeout flag", 32'(timeout_err), 1);
        chk("timeout match_count", 32'(match_count), 0);
        chk("timeout sample_count", 32'(sample_count), 2);

        // reset at pixel 400 of sample 0 (address 400 issued in cycle 401)
        lbl[0] = 4; cls[0] = 4; lat[0] = 10;
        run("abort", 1, 0, 401);
        lbl[0] = 2; cls[0] = 2; lat[0] = 8;
        run("restart", 1, 0, 0);

        // second start with num_samples=5 while busy is ignored
        lbl[0] = 1; lbl[1] = 8; cls[0] = 1; cls[1] = 0; lat[0] = 6; lat[1] = 3;
        run("restart_ignored", 2, 100, 0);
        chk("restart_ignored sample_count", 32'(sample_count), 2);

        // answer in the very last wait cycle still counts as a match
        lbl[0] = 6; cls[0] = 6; lat[0] = TMO - 1;
        run("late_answer", 1, 0, 0);
        chk("late_answer timeout_err", 32'(timeout_err), 0);

        // randomized runs, including labels with high bits set
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 4; s++) begin
                cls[s] = $urandom_range(0, 9);
                if ($urandom_range(0, 3) == 0)      lbl[s] = int'(DW'($urandom));
                else if ($urandom_range(0, 1) == 0) lbl[s] = cls[s];
                else                                lbl[s] = $urandom_range(0, 9);
                lat[s] = $urandom_range(2, 40);
            end
            run($sformatf("random%0d", k), 4, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
